// File: rtl/riscv_loader_pkg.sv
// riscv_loader_pkg: shared loader states and sizing constants
package riscv_loader_pkg;
  typedef enum logic [2:0] {LEN_LO, LEN_HI, PAYLOAD, CSUM, DONE, ERROR} state_e;
  localparam int HDR_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int IMEM_AW = 32;
endpackage

// File: rtl/loader_word_packer.sv
// loader_word_packer: packs incoming bytes little-endian into a 32-bit word
module loader_word_packer
  import riscv_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  idx_i,
  input  logic        load_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);
  logic [31:0] word_q, word_d;
  // drop the byte into its lane; word_o already includes the byte being loaded
  always_comb begin
    word_d = word_q;
    if (load_i) word_d[8*idx_i +: 8] = byte_i;
  end
  // pack register
  always_ff @(posedge clk) begin
    if (!rst_n) word_q <= '0;
    else word_q <= word_d;
  end
  assign word_o = word_d;
  assign word_full_o = load_i && (idx_i == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: byte-stream program loader that holds the core in reset until a verified load
module imem_boot_loader
  import riscv_loader_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  output logic               core_rst_n,
  output logic               load_done,
  output logic               load_error,
  output logic [CNT_W-1:0]   words_loaded
);
  state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d, new_len;
  logic [7:0] csum_q, csum_d;
  logic [IMEM_AW-1:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d, word;
  logic rdy_q, we_q, we_d, done_q, err_q, core_q;
  logic acc, pay_ld, full;
  assign acc = rx_valid && rdy_q;
  assign pay_ld = acc && (state_q == PAYLOAD);
  assign new_len = CNT_W'({rx_data, len_q[7:0]});
  loader_word_packer u_pack (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_i      (rx_data),
    .idx_i       (idx_q),
    .load_i      (pay_ld),
    .word_o      (word),
    .word_full_o (full)
  );
  // stream parser: header, payload packing with running XOR, checksum verdict
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    len_d = len_q;
    csum_d = csum_q;
    we_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (acc) begin
      case (state_q)
        LEN_LO: begin
          len_d = CNT_W'(rx_data);
          state_d = LEN_HI;
        end
        LEN_HI: begin
          len_d = new_len;
          state_d = (new_len == '0 || new_len > CNT_W'(MAX_WORDS)) ? ERROR : PAYLOAD;
        end
        PAYLOAD: begin
          csum_d = csum_q ^ rx_data;
          idx_d = idx_q + 2'd1;
          if (full) begin
            we_d = 1'b1;
            waddr_d = IMEM_AW'({cnt_q, 2'b00});
            wdata_d = word;
            cnt_d = cnt_q + CNT_W'(1);
            state_d = (cnt_d == len_q) ? CSUM : PAYLOAD;
          end
        end
        CSUM: state_d = (rx_data == csum_q) ? DONE : ERROR;
        default: state_d = state_q;
      endcase
    end
  end
  // state and registered outputs; terminal states drop rx_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LEN_LO;
      idx_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      csum_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      rdy_q <= 1'b0;
      we_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      core_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      csum_q <= csum_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdy_q <= !(state_d == DONE || state_d == ERROR);
      we_q <= we_d;
      done_q <= state_d == DONE;
      err_q <= state_d == ERROR;
      core_q <= state_d == DONE;
    end
  end
  assign rx_ready = rdy_q;
  assign imem_we = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign core_rst_n = core_q;
  assign load_done = done_q;
  assign load_error = err_q;
  assign words_loaded = cnt_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: table vectors, corner sequences and random streams against a stream-level model
module tb_imem_boot_loader;
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_ready, imem_we, core_rst_n, load_done, load_error;
  logic [31:0] imem_waddr, imem_wdata;
  logic [15:0] words_loaded;

  imem_boot_loader dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .load_done(load_done), .load_error(load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:15][7:0] b;
    logic [7:0]       n;
    logic             done;
    logic             err;
    logic [7:0]       words;
    logic [7:0]       nw;
    logic [0:2][31:0] wd;
  } vec_t;

  vec_t tbl[5];
  int tests = 0, fails = 0;
  logic [7:0] stim[$];
  logic [63:0] wq[$], eq[$];
  bit e_done, e_err, prev_we;
  int e_words;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // write monitor: records each IMEM write and checks pulse shape / counter alignment
  always @(negedge clk) begin
    if (imem_we) begin
      wq.push_back({imem_waddr, imem_wdata});
      chk("we_single_cycle", 64'(prev_we), 64'd0);
      chk("words_vs_addr", 64'(words_loaded) * 4, 64'(imem_waddr) + 4);
    end
    prev_we = imem_we;
  end

  // reference: interpret the byte stream by its format rules
  task automatic model();
    int len;
    logic [7:0] cs;
    logic [31:0] wd;
    eq.delete();
    cs = 8'h00;
    e_done = 0;
    e_err = 0;
    e_words = 0;
    len = {stim[1], stim[0]};
    if (len == 0 || len > 256) begin
      e_err = 1;
      return;
    end
    for (int w = 0; w < len; w++) begin
      for (int k = 0; k < 4; k++) begin
        wd[8*k +: 8] = stim[2 + 4*w + k];
        cs ^= stim[2 + 4*w + k];
      end
      eq.push_back({32'(4 * w), wd});
    end
    e_words = len;
    if (stim[2 + 4*len] == cs) e_done = 1;
    else e_err = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("reset_ctl", {rx_ready, imem_we, core_rst_n, load_done, load_error, words_loaded}, 64'd0);
    chk("reset_waddr", 64'(imem_waddr), 64'd0);
    chk("reset_wdata", 64'(imem_wdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(rx_ready), 64'd1);
    wq.delete();
  endtask

  task automatic drive(input int gmax);
    for (int i = 0; i < stim.size(); i++) begin
      int g = $urandom_range(gmax, 0);
      repeat (g) begin
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
        @(negedge clk);
      end
      if (!rx_ready) break;
      rx_valid = 1'b1;
      rx_data = stim[i];
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic finish_check(input string nm);
    chk({nm, "_done_now"}, 64'(load_done), 64'(e_done));
    chk({nm, "_err_now"}, 64'(load_error), 64'(e_err));
    chk({nm, "_core_now"}, 64'(core_rst_n), 64'(e_done));
    repeat (2) @(negedge clk);
    chk({nm, "_ready_term"}, 64'(rx_ready), 64'd0);
    chk({nm, "_core_term"}, 64'(core_rst_n), 64'(e_done));
    chk({nm, "_words"}, 64'(words_loaded), 64'(e_words));
    chk({nm, "_nwrites"}, 64'(wq.size()), 64'(eq.size()));
    for (int i = 0; i < eq.size() && i < wq.size(); i++) chk({nm, "_write"}, wq[i], eq[i]);
  endtask

  task automatic load_vec(input int t);
    stim.delete();
    for (int i = 0; i < int'(tbl[t].n); i++) stim.push_back(tbl[t].b[i]);
  endtask

  task automatic exp_vec(input int t);
    eq.delete();
    e_done = tbl[t].done;
    e_err = tbl[t].err;
    e_words = tbl[t].words;
    for (int i = 0; i < int'(tbl[t].nw); i++) eq.push_back({32'(4 * i), tbl[t].wd[i]});
  endtask

  initial begin
    tbl[0] = '{b: {8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6, {9{8'h00}}}, n: 7,
               done: 1, err: 0, words: 1, nw: 1, wd: {32'h00A00513, 32'h0, 32'h0}};
    tbl[1] = '{b: {8'h03, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                   8'h33, 8'h81, 8'h20, 8'h00, 8'h02, 8'h00}, n: 15,
               done: 1, err: 0, words: 3, nw: 3, wd: {32'h00000013, 32'h00100093, 32'h00208133}};
    tbl[2] = '{b: {8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h00, {9{8'h00}}}, n: 7,
               done: 0, err: 1, words: 1, nw: 1, wd: {32'h00A00513, 32'h0, 32'h0}};
    tbl[3] = '{b: {8'h00, 8'h00, 8'h13, 8'h05, {12{8'h00}}}, n: 4,
               done: 0, err: 1, words: 0, nw: 0, wd: '0};
    tbl[4] = '{b: {8'h01, 8'h01, 8'h13, 8'h05, 8'hA0, 8'h00, {10{8'h00}}}, n: 6,
               done: 0, err: 1, words: 0, nw: 0, wd: '0};

    for (int t = 0; t < 5; t++) begin
      do_reset();
      load_vec(t);
      drive(0);
      exp_vec(t);
      finish_check($sformatf("vec%0d", t));
    end

    do_reset();
    load_vec(1);
    drive(5);
    exp_vec(1);
    finish_check("gaps");

    do_reset();
    load_vec(1);
    stim = stim[0:7];
    drive(0);
    repeat (2) @(negedge clk);
    chk("midload_writes", 64'(wq.size()), 64'd1);
    chk("midload_core", 64'(core_rst_n), 64'd0);
    do_reset();
    chk("midload_words_cleared", 64'(words_loaded), 64'd0);
    load_vec(0);
    drive(0);
    exp_vec(0);
    finish_check("reload");

    for (int r = 0; r < 20; r++) begin
      int len;
      logic [7:0] cs, b;
      stim.delete();
      len = ($urandom_range(9, 0) < 8) ? $urandom_range(5, 1) : (($urandom_range(1, 0) == 1) ? 0 : 257);
      stim.push_back(8'(len));
      stim.push_back(8'(len >> 8));
      cs = 8'h00;
      if (len == 0 || len > 256) begin
        repeat (3) stim.push_back(8'($urandom));
      end else begin
        for (int i = 0; i < 4 * len; i++) begin
          b = 8'($urandom);
          cs ^= b;
          stim.push_back(b);
        end
        stim.push_back(($urandom_range(9, 0) < 7) ? cs : cs ^ 8'($urandom_range(255, 1)));
      end
      do_reset();
      model();
      drive($urandom_range(3, 0));
      finish_check($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream stage of the single-cycle RISC-V core.
- Receives a program as a byte stream over a valid/ready handshake, packs the bytes little-endian into 32-bit words, and writes them sequentially into instruction memory from byte address 0.
- Holds the core in reset while loading. Releases the core only after a length-checked, checksum-verified load completes.

Parameters:
- MAX_WORDS, 256, maximum program length in 32-bit words; must be at most 65535.
- CNT_W, 16, width of the word counter and the length field.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- rx_valid  input  1  rx_data holds a valid byte
- rx_data  input  8  incoming byte
- rx_ready  output  1  loader accepts the byte this cycle
- imem_we  output  1  IMEM write strobe, one-cycle pulse
- imem_waddr  output  32  IMEM byte address, word aligned
- imem_wdata  output  32  IMEM write data
- core_rst_n  output  1  reset to the core, active-low
- load_done  output  1  load completed, checksum OK
- load_error  output  1  load aborted (bad length or checksum)
- words_loaded  output  CNT_W  number of words written so far

Behaviour:
- Reset is synchronous on clk; rst_n is sampled only at the rising edge. While rst_n=0 at an edge, all outputs and state are cleared:
  - rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0
  - core_rst_n=0, load_done=0, load_error=0, words_loaded=0
  - state=LEN_LO, byte index=0, checksum=0
- Handshake: a byte is accepted at an edge where rx_valid=1 and rx_ready=1. No other byte counts.
  - rx_ready is a registered 1 in LEN_LO, LEN_HI, PAYLOAD and CSUM, and 0 in DONE and ERROR.
  - rx_data is ignored when rx_valid=0.
- Stream format: LEN_LO, LEN_HI, then 4*LEN payload bytes, then one CSUM byte.
  - LEN is a 16-bit word count.
  - CSUM is the XOR of all payload bytes; header bytes are excluded.
- States and transitions:
  - LEN_LO: accept a byte, store it as len[7:0], go to LEN_HI.
  - LEN_HI: accept a byte, store it as len[15:8]. If the new len is 0 or greater than MAX_WORDS, go to ERROR; otherwise go to PAYLOAD.
  - PAYLOAD: byte k (k=0..3) of the current word goes to bits [8k+7:8k], and every byte is XORed into the checksum. On the 4th byte, issue the write (see below). When the last word's 4th byte is accepted, go to CSUM.
  - CSUM: accept a byte. If it equals the accumulated checksum, go to DONE; otherwise go to ERROR.
  - DONE: terminal state; load_done=1, core_rst_n=1.
  - ERROR: terminal state; load_error=1, core_rst_n stays 0.
  - Only rst_n leaves DONE or ERROR.
- Write timing: the 4th byte of word n is accepted at edge E. In the cycle after E:
  - imem_we=1, imem_waddr=4*n, imem_wdata = the full packed word
  - words_loaded = n+1
  - imem_we drops to 0 the following cycle unless another write is issued.
- Back-to-back writes are not possible, because a word needs at least 4 accepted bytes.
- All outputs are registered. core_rst_n and load_done rise in the cycle after the CSUM byte is accepted.
- The byte index wraps 3→0 on each word. The word counter never exceeds len, because the transition to CSUM is taken exactly at count=len.
- When rx_valid toggles (gaps), the packing state is held. There is no timeout.
- Reset mid-load returns the block to LEN_LO, and core_rst_n returns to 0. IMEM contents already written are not cleared; the next load overwrites them from address 0.
- Bytes presented in DONE or ERROR are never accepted (rx_ready=0).

Decomposition:
- Shared package riscv_loader_pkg holds:
  - the state enum (LEN_LO, LEN_HI, PAYLOAD, CSUM, DONE, ERROR)
  - HDR_BYTES=2 and BYTES_PER_WORD=4 constants
  - the IMEM address width constant shared with IMEM.
- One sub-module, loader_word_packer, is natural:
  - takes a byte, its byte index and the load strobe;
  - holds the 32-bit shift/pack register;
  - emits word_full.
- The FSM, counter, checksum and output registers stay in imem_boot_loader.

Test Plan:
1. Reset then stream 01 00 13 05 A0 00 B6 (len=1, word 0x00A00513, checksum 0xB6) → one imem_we pulse with waddr=0x0 and wdata=0x00A00513. The cycle after the checksum byte: core_rst_n=1, load_done=1, words_loaded=1.
2. len=3 with words 0x00000013, 0x00100093, 0x00208133 and the correct XOR checksum → write pulses at addresses 0x0, 0x4, 0x8 with matching data, then DONE.
3. Same stream as 1 but checksum byte 0x00 → no core release; load_error=1, core_rst_n=0, rx_ready=0.
4. Header 00 00 → ERROR right after LEN_HI; no imem_we. Header 01 01 (257 > MAX_WORDS) → ERROR.
5. Scenario 2 with rx_valid deasserted for random 0-5 cycles between bytes → identical writes and result.
6. Assert rst_n=0 after 6 payload bytes of scenario 2, then replay scenario 1 → word 0 rewritten with 0x00A00513, then DONE with words_loaded=1.
